// File: rtl/j1_pkg.sv
// Shared definitions for the j1 stack CPU: sizes, instruction field layout and ALU opcodes.
package j1_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned ADDR_W      = 13;
  localparam int unsigned RAM_DEPTH   = 8192;
  localparam int unsigned STACK_DEPTH = 32;
  localparam int unsigned SP_W        = 5;

  localparam int unsigned LIT_BIT = 15;
  localparam int unsigned OPC_HI  = 14;
  localparam int unsigned OPC_LO  = 13;

  // Instruction class in insn[14:13] when insn[15] is clear.
  typedef enum logic [1:0] {
    OPC_JUMP    = 2'b00,
    OPC_ZBRANCH = 2'b01,
    OPC_CALL    = 2'b10,
    OPC_ALU     = 2'b11
  } opc_e;

  typedef enum logic [3:0] {
    ALU_T     = 4'd0,
    ALU_N     = 4'd1,
    ALU_ADD   = 4'd2,
    ALU_AND   = 4'd3,
    ALU_OR    = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_INV   = 4'd6,
    ALU_EQ    = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_RSH   = 4'd9,
    ALU_DEC   = 4'd10,
    ALU_R     = 4'd11,
    ALU_LOAD  = 4'd12,
    ALU_LSH   = 4'd13,
    ALU_DEPTH = 4'd14,
    ALU_ULT   = 4'd15
  } alu_op_e;

  // ALU instruction fields: insn[12:5] and insn[3:0]; insn[4] is reserved.
  typedef struct packed {
    logic       r2pc;
    alu_op_e    op;
    logic       t2n;
    logic       t2r;
    logic       n2mem;
    logic [1:0] rdelta;
    logic [1:0] ddelta;
  } alu_fields_t;

  function automatic logic [SP_W-1:0] sext_delta(input logic [1:0] d);
    return {{(SP_W-2){d[1]}}, d};
  endfunction

endpackage

// File: rtl/j1_ram.sv
// 8K x 16 program/data RAM: registered instruction port, combinational data port, loader write port.
module j1_ram
  import j1_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [WORD_W-1:0] i_data,
  input  logic [ADDR_W-1:0] d_addr,
  output logic [WORD_W-1:0] d_rdata,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_wdata,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic              l_we,
  input  logic [WORD_W-1:0] l_data
);

  logic [WORD_W-1:0] mem [RAM_DEPTH];
  logic [WORD_W-1:0] i_data_q, i_data_d;

  // Writes landing on the word about to be fetched are forwarded, loader last so it wins.
  always_comb begin
    // NOTE: default assigned first so every path drives i_data_d; no latch is inferred.
    i_data_d = mem[i_addr];
    if (d_we && (d_addr == i_addr)) i_data_d = d_wdata;
    if (l_we && (l_addr == i_addr)) i_data_d = l_data;
  end

  // NOTE: mem has no reset; its contents survive reset and a reset port would prevent RAM inference.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every clocked read this edge sees pre-edge values.
    i_data_q <= i_data_d;
    if (d_we) mem[d_addr] <= d_wdata;
    if (l_we) mem[l_addr] <= l_data;
  end

  assign i_data  = i_data_q;
  assign d_rdata = mem[d_addr];

endmodule

// File: rtl/j1.sv
// j1: 16-bit J1-style Forth CPU executing one instruction per clock.
// Data stack is T (st0_q) over a 32-entry N stack; the return stack is 32 entries.
module j1
  import j1_pkg::*;
(
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic [WORD_W-1:0] io_din,
  output logic              io_rd,
  output logic              io_wr,
  output logic [WORD_W-1:0] io_addr,
  output logic [WORD_W-1:0] io_dout,
  input  logic [ADDR_W-1:0] pgm_addr,
  input  logic [WORD_W-1:0] pgm_data,
  input  logic              pgm_we
);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus1;
  logic [WORD_W-1:0] st0_q, st0_d;
  logic [SP_W-1:0]   dsp_q, dsp_d, rsp_q, rsp_d;
  logic [WORD_W-1:0] insn, st1, rst0, alu_res, ram_rdata;

  logic [WORD_W-1:0] dstack [STACK_DEPTH];
  logic [WORD_W-1:0] rstack [STACK_DEPTH];

  logic              dstack_we, rstack_we, ram_we;
  logic [SP_W-1:0]   dstack_waddr, rstack_waddr;
  logic [WORD_W-1:0] rstack_wdata;

  alu_fields_t       alu_f;
  opc_e              opc;
  logic              unused_insn_bit;

  assign alu_f           = alu_fields_t'({insn[12:5], insn[3:0]});
  assign opc             = opc_e'(insn[OPC_HI:OPC_LO]);
  assign unused_insn_bit = insn[4];

  assign st1      = dstack[dsp_q];
  assign rst0     = rstack[rsp_q];
  assign pc_plus1 = pc_q + 13'd1;
  assign io_addr  = st0_q;
  assign io_dout  = st1;

  j1_ram memory (
    .clk     (sys_clk_i),
    .i_addr  (pc_d),
    .i_data  (insn),
    .d_addr  (st0_q[13:1]),
    .d_rdata (ram_rdata),
    .d_we    (ram_we),
    .d_wdata (st1),
    .l_addr  (pgm_addr),
    .l_we    (pgm_we),
    .l_data  (pgm_data)
  );

  always_comb begin
    alu_res = st0_q;
    unique case (alu_f.op)
      ALU_T:     alu_res = st0_q;
      ALU_N:     alu_res = st1;
      ALU_ADD:   alu_res = st0_q + st1;
      ALU_AND:   alu_res = st0_q & st1;
      ALU_OR:    alu_res = st0_q | st1;
      ALU_XOR:   alu_res = st0_q ^ st1;
      ALU_INV:   alu_res = ~st0_q;
      ALU_EQ:    alu_res = {WORD_W{st1 == st0_q}};
      ALU_SLT:   alu_res = {WORD_W{$signed(st1) < $signed(st0_q)}};
      ALU_RSH:   alu_res = st1 >> st0_q[3:0];
      ALU_DEC:   alu_res = st0_q - 16'd1;
      ALU_R:     alu_res = rst0;
      ALU_LOAD:  alu_res = st0_q[15] ? io_din : ram_rdata;
      ALU_LSH:   alu_res = st1 << st0_q[3:0];
      ALU_DEPTH: alu_res = {11'b0, dsp_q};
      ALU_ULT:   alu_res = {WORD_W{st1 < st0_q}};
    endcase
  end

  always_comb begin
    pc_d         = pc_plus1;
    st0_d        = st0_q;
    dsp_d        = dsp_q;
    rsp_d        = rsp_q;
    dstack_we    = 1'b0;
    dstack_waddr = dsp_q;
    rstack_we    = 1'b0;
    rstack_waddr = rsp_q;
    rstack_wdata = st0_q;
    ram_we       = 1'b0;
    io_rd        = 1'b0;
    io_wr        = 1'b0;

    if (insn[LIT_BIT]) begin
      dsp_d        = dsp_q + 5'd1;
      dstack_we    = 1'b1;
      dstack_waddr = dsp_d;
      st0_d        = {1'b0, insn[14:0]};
    end else begin
      unique case (opc)
        OPC_JUMP: pc_d = insn[12:0];
        OPC_ZBRANCH: begin
          pc_d  = (st0_q == '0) ? insn[12:0] : pc_plus1;
          st0_d = st1;
          dsp_d = dsp_q - 5'd1;
        end
        OPC_CALL: begin
          rsp_d        = rsp_q + 5'd1;
          rstack_we    = 1'b1;
          rstack_waddr = rsp_d;
          rstack_wdata = {2'b00, pc_plus1, 1'b0};
          pc_d         = insn[12:0];
        end
        OPC_ALU: begin
          st0_d        = alu_res;
          dsp_d        = dsp_q + sext_delta(alu_f.ddelta);
          rsp_d        = rsp_q + sext_delta(alu_f.rdelta);
          dstack_we    = alu_f.t2n;
          dstack_waddr = dsp_d;
          rstack_we    = alu_f.t2r;
          rstack_waddr = rsp_d;
          if (alu_f.r2pc) pc_d = rst0[13:1];
          if (alu_f.n2mem) begin
            io_wr  = st0_q[15];
            ram_we = ~st0_q[15];
          end
          io_rd = (alu_f.op == ALU_LOAD) && st0_q[15];
        end
      endcase
    end

    // Reset fetches from address 0 and suppresses every side effect; stacks and RAM keep their data.
    if (sys_rst_i) begin
      pc_d      = '0;
      dstack_we = 1'b0;
      rstack_we = 1'b0;
      ram_we    = 1'b0;
      io_rd     = 1'b0;
      io_wr     = 1'b0;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      pc_q  <= '0;
      st0_q <= '0;
      dsp_q <= '0;
      rsp_q <= '0;
    end else begin
      pc_q  <= pc_d;
      st0_q <= st0_d;
      dsp_q <= dsp_d;
      rsp_q <= rsp_d;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (dstack_we) dstack[dstack_waddr] <= st0_q;
    if (rstack_we) rstack[rstack_waddr] <= rstack_wdata;
  end

endmodule

// File: tb/tb_j1.sv
// Self-checking bench for j1: an instruction-level interpreter predicts T, N and the I/O strobes every cycle.
module tb_j1;

  logic        sys_clk_i = 1'b0;
  logic        sys_rst_i = 1'b1;
  logic [15:0] io_din    = '0;
  logic        io_rd, io_wr;
  logic [15:0] io_addr, io_dout;
  logic [12:0] pgm_addr  = '0;
  logic [15:0] pgm_data  = '0;
  logic        pgm_we    = 1'b0;

  always #5 sys_clk_i = ~sys_clk_i;

  j1 dut (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .io_din    (io_din),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_addr   (io_addr),
    .io_dout   (io_dout),
    .pgm_addr  (pgm_addr),
    .pgm_data  (pgm_data),
    .pgm_we    (pgm_we)
  );

  // Architectural model of the machine.
  logic [15:0] m_ram [8192];
  logic [15:0] m_ds  [32];
  logic [15:0] m_rs  [32];
  logic [12:0] m_pc;
  logic [15:0] m_t;
  logic [4:0]  m_dsp, m_rsp;
  bit          m_tvalid = 1'b0;
  bit          m_nvalid = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] prog [$];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic int delta(input logic [1:0] d);
    case (d)
      2'b01:   return 1;
      2'b10:   return -2;
      2'b11:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [15:0] t, input logic [15:0] n,
                                            input logic [15:0] r, input logic [15:0] mw, input logic [15:0] din,
                                            input logic [4:0] dsp);
    case (op)
      4'd0:    return t;
      4'd1:    return n;
      4'd2:    return t + n;
      4'd3:    return t & n;
      4'd4:    return t | n;
      4'd5:    return t ^ n;
      4'd6:    return ~t;
      4'd7:    return (n == t) ? 16'hFFFF : 16'h0000;
      4'd8:    return ($signed(n) < $signed(t)) ? 16'hFFFF : 16'h0000;
      4'd9:    return n >> t[3:0];
      4'd10:   return t - 16'd1;
      4'd11:   return r;
      4'd12:   return t[15] ? din : mw;
      4'd13:   return n << t[3:0];
      4'd14:   return {11'b0, dsp};
      default: return (n < t) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  task automatic compare_model(input logic r);
    logic [15:0] ins;
    logic        is_alu, exp_rd, exp_wr;
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    if (!r) begin
      ins    = m_ram[m_pc];
      is_alu = (ins[15:13] == 3'b011);
      exp_rd = is_alu && (ins[11:8] == 4'd12) && m_t[15];
      exp_wr = is_alu && ins[5] && m_t[15];
    end
    check("io_rd", {15'b0, io_rd}, {15'b0, exp_rd});
    check("io_wr", {15'b0, io_wr}, {15'b0, exp_wr});
    if (m_tvalid) check("io_addr(T)", io_addr, m_t);
    if (m_nvalid) check("io_dout(N)", io_dout, m_ds[m_dsp]);
  endtask

  task automatic step_model(input logic r, input logic we, input logic [12:0] a, input logic [15:0] d,
                            input logic [15:0] din);
    logic [15:0] ins, n, rv, t_new;
    logic [12:0] pc_n, pc1;
    logic [4:0]  dsp_old;
    if (r) begin
      m_pc = '0; m_t = '0; m_dsp = '0; m_rsp = '0;
      m_tvalid = 1'b1;
    end else begin
      ins     = m_ram[m_pc];
      n       = m_ds[m_dsp];
      rv      = m_rs[m_rsp];
      pc1     = m_pc + 13'd1;
      pc_n    = pc1;
      t_new   = m_t;
      dsp_old = m_dsp;
      if (ins[15]) begin
        m_dsp++;
        m_ds[m_dsp] = m_t;
        t_new = {1'b0, ins[14:0]};
      end else begin
        case (ins[14:13])
          2'd0: pc_n = ins[12:0];
          2'd1: begin
            if (m_t == 16'h0) pc_n = ins[12:0];
            t_new = n;
            m_dsp--;
          end
          2'd2: begin
            m_rsp++;
            m_rs[m_rsp] = {2'b00, pc1, 1'b0};
            pc_n = ins[12:0];
          end
          default: begin
            t_new = alu_model(ins[11:8], m_t, n, rv, m_ram[m_t[13:1]], din, dsp_old);
            if (ins[5] && !m_t[15]) m_ram[m_t[13:1]] = n;
            m_dsp = m_dsp + 5'(delta(ins[1:0]));
            m_rsp = m_rsp + 5'(delta(ins[3:2]));
            if (ins[7]) m_ds[m_dsp] = m_t;
            if (ins[6]) m_rs[m_rsp] = m_t;
            if (ins[12]) pc_n = rv[13:1];
          end
        endcase
      end
      m_pc = pc_n;
      m_t  = t_new;
    end
    if (we) m_ram[a] = d;
  endtask

  task automatic tick(input logic r, input logic we, input logic [12:0] a, input logic [15:0] d,
                      input logic [15:0] din);
    @(negedge sys_clk_i);
    sys_rst_i = r;
    pgm_we    = we;
    pgm_addr  = a;
    pgm_data  = d;
    io_din    = din;
    #1;
    compare_model(r);
    step_model(r, we, a, d, din);
  endtask

  task automatic load_prog();
    foreach (prog[i]) tick(1'b1, 1'b1, 13'(i), prog[i], 16'h0);
    tick(1'b1, 1'b0, '0, '0, 16'h0);
    tick(1'b1, 1'b0, '0, '0, 16'h0);
    prog.delete();
  endtask

  task automatic run(input int cycles, input logic [15:0] din);
    for (int i = 0; i < cycles; i++) tick(1'b0, 1'b0, '0, '0, din);
  endtask

  initial begin
    // Fill both stacks so N and R are defined for the rest of the run.
    for (int i = 0; i < 32; i++) prog.push_back(16'h8000 | 16'((i * 1117 + 3) & 16'h7FFF));
    for (int i = 0; i < 32; i++) prog.push_back(16'h6044);
    prog.push_back(16'h0040);
    load_prog();
    run(66, 16'h0);
    m_nvalid = 1'b1;

    // Literals 5, 3, ADD with dstack -1, then push depth.
    prog = '{16'h8005, 16'h8003, 16'h6203, 16'h6E81, 16'h0004};
    load_prog();
    run(1, 16'h0);
    check("reset_T", io_addr, 16'h0000);
    check("reset_rd", {15'b0, io_rd}, 16'h0);
    run(3, 16'h0);
    check("add_T", io_addr, 16'h0008);
    run(1, 16'h0);
    check("add_dsp", io_addr, 16'h0001);
    check("add_N", io_dout, 16'h0008);

    // I/O write: 1234 to address C000.
    prog = '{16'h9234, 16'hBFFF, 16'h6600, 16'h6023, 16'h0004};
    load_prog();
    run(4, 16'h0);
    check("iowr_strobe", {15'b0, io_wr}, 16'h0001);
    check("iowr_addr", io_addr, 16'hC000);
    check("iowr_data", io_dout, 16'h1234);
    run(1, 16'h0);
    check("iowr_pulse_end", {15'b0, io_wr}, 16'h0000);

    // I/O read from C002.
    prog = '{16'hBFFD, 16'h6600, 16'h6C00, 16'h0003};
    load_prog();
    run(3, 16'hABCD);
    check("iord_strobe", {15'b0, io_rd}, 16'h0001);
    check("iord_addr", io_addr, 16'hC002);
    run(1, 16'hABCD);
    check("iord_pulse_end", {15'b0, io_rd}, 16'h0000);
    check("iord_T", io_addr, 16'hABCD);

    // Call 0x010 and return to caller+1.
    prog = '{16'h8001, 16'h4010, 16'h8002, 16'h0003};
    while (prog.size() < 16) prog.push_back(16'h0000);
    prog.push_back(16'h700C);
    load_prog();
    run(5, 16'h0);
    check("ret_T", io_addr, 16'h0002);
    check("ret_N", io_dout, 16'h0001);

    // 0branch taken on T=0, not taken on T=1; both pop.
    prog = '{16'h8000, 16'h8000, 16'h2005, 16'h8007, 16'h0004, 16'h8001,
             16'h200A, 16'h8011, 16'h6E81, 16'h0009, 16'h8022, 16'h000B};
    load_prog();
    run(7, 16'h0);
    check("zbr_path_T", io_addr, 16'h0011);
    run(1, 16'h0);
    check("zbr_depth", io_addr, 16'h0002);
    check("zbr_N", io_dout, 16'h0011);

    // Store 0055 to byte 0x0100, load it back, then loader patches word 5 while running.
    prog = '{16'h8055, 16'h8100, 16'h6023, 16'h6C00, 16'h0005, 16'h0005, 16'h0006};
    load_prog();
    run(3, 16'h0);
    tick(1'b0, 1'b1, 13'h0005, 16'h8007, 16'h0);
    run(1, 16'h0);
    check("mem_load_T", io_addr, 16'h0055);
    run(2, 16'h0);
    check("loader_patch_T", io_addr, 16'h0007);

    // Loader write wins over a CPU store to the same word.
    prog = '{16'h8066, 16'h8100, 16'h6023, 16'h6C00, 16'h0004};
    load_prog();
    run(2, 16'h0);
    tick(1'b0, 1'b1, 13'h0080, 16'h1234, 16'h0);
    run(2, 16'h0);
    check("loader_priority_T", io_addr, 16'h1234);

    // Random program image executed in several episodes with random I/O data and loader traffic.
    for (int i = 0; i < 8192; i++) tick(1'b1, 1'b1, 13'(i), 16'($urandom()), 16'h0);
    for (int e = 0; e < 4; e++) begin
      tick(1'b1, 1'b0, '0, '0, 16'h0);
      tick(1'b1, 1'b0, '0, '0, 16'h0);
      for (int c = 0; c < 1500; c++) begin
        logic [15:0] ins;
        logic        we;
        logic [12:0] a;
        ins = m_ram[m_pc];
        we  = ($urandom_range(7) == 0);
        a   = 13'($urandom());
        if ((ins[15:13] == 3'b011) && ins[5] && !m_t[15] && ($urandom_range(1) == 1)) begin
          we = 1'b1;
          a  = m_t[13:1];
        end
        tick(1'b0, we, a, 16'($urandom()), 16'($urandom()));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
